// File: rtl/seq_bin_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state codes,
// default operand width and the iteration counter sizing helper.
package seq_bin_divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Counter must hold WIDTH-1; a 1-bit counter is the floor for WIDTH=2.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_bin_divider_if.sv
// Start/done handshake bundle between a requester (master) and the divider (slave).
interface seq_bin_divider_if
    import seq_bin_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);
    // start is honoured only while busy is low; operands are captured on that
    // edge. done pulses for one cycle with quotient/remainder/div_by_zero valid,
    // and those results hold until the next accepted start.
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_bin_divider_div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not borrow.
module div_step
    import seq_bin_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   r_shift_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   r_next_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] trial;

    // The extra top bit carries the borrow; the remainder invariant R < D keeps
    // the shifted value below 2*D so no wider datapath is needed.
    assign trial    = r_shift_i - {1'b0, d_i};
    assign q_bit_o  = ~trial[WIDTH];
    assign r_next_o = q_bit_o ? trial : r_shift_i;

endmodule

// File: rtl/seq_bin_divider.sv
// Sequential unsigned restoring divider producing one quotient bit per clock,
// with registered results that stay stable while the next division runs.
module seq_bin_divider
    import seq_bin_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    seq_bin_divider_if.slave    bus_if,
    output state_t              state_o
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_step;
    logic             q_bit;

    assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_shift_i (r_shift),
        .d_i       (d_q),
        .r_next_o  (r_step),
        .q_bit_o   (q_bit)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    q_d   = bus_if.dividend;
                    d_d   = bus_if.divisor;
                    r_d   = '0;
                    cnt_d = CW'(WIDTH - 1);
                    // A zero divisor short-circuits straight to the result.
                    if (bus_if.divisor == '0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = bus_if.dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        dbz_d   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                r_d = r_step;
                q_d = {q_q[WIDTH-2:0], q_bit};
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    quot_d  = q_d;
                    rem_d   = r_step[WIDTH-1:0];
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign bus_if.busy        = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus_if.done        = done_q;
    assign bus_if.quotient    = quot_q;
    assign bus_if.remainder   = rem_q;
    assign bus_if.div_by_zero = dbz_q;
    assign state_o            = state_q;

endmodule
